// File: rtl/imem_loader.sv
// Instruction memory loader: unpacks a framed byte stream (LEN, payload, CHK)
// into instruction words, writes them from address 0 and holds the CPU while loading.
module imem_loader #(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [7:0]         rx_data_i,
  input  logic               rx_valid_i,
  output logic               rx_ready_o,
  output logic               imem_we_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  output logic [INSTR_W-1:0] imem_data_o,
  output logic               cpu_hold_o,
  output logic               done_o,
  output logic               err_o,
  output logic [ADDR_W:0]    count_o
);
  localparam int BPW       = INSTR_W / 8;
  localparam int BC_W      = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int MAX_WORDS = 1 << ADDR_W;

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WR, S_CHK, S_DONE, S_ERR} state_t;

  state_t             state;
  logic [7:0]         acc;
  logic [ADDR_W:0]    n_words;
  logic [BC_W-1:0]    bcnt;
  logic [INSTR_W-1:0] word;
  logic [INSTR_W-1:0] word_nxt;
  logic [ADDR_W:0]    count_inc;
  logic               take;

  assign take      = rx_ready_o & rx_valid_i;
  assign count_inc = count_o + 1'b1;

  // Payload arrives MSB first, so each byte shifts in at the bottom.
  if (BPW > 1) begin : g_shift
    assign word_nxt = {word[INSTR_W-9:0], rx_data_i};
  end else begin : g_byte
    assign word_nxt = rx_data_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      rx_ready_o  <= 1'b0;
      imem_we_o   <= 1'b0;
      imem_addr_o <= '0;
      imem_data_o <= '0;
      cpu_hold_o  <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      count_o     <= '0;
      acc         <= '0;
      n_words     <= '0;
      bcnt        <= '0;
      word        <= '0;
    end else begin
      imem_we_o <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            state      <= S_LEN;
            rx_ready_o <= 1'b1;
            cpu_hold_o <= 1'b1;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            count_o    <= '0;
            acc        <= '0;
            bcnt       <= '0;
          end
        end
        S_LEN: begin
          if (take) begin
            acc     <= rx_data_i;
            n_words <= (ADDR_W+1)'(rx_data_i);
            // Only reachable for address spaces narrower than 256 words.
            if (int'(rx_data_i) > MAX_WORDS) begin
              state      <= S_ERR;
              rx_ready_o <= 1'b0;
              err_o      <= 1'b1;
            end else if (rx_data_i == 8'h00) begin
              state <= S_CHK;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (take) begin
            acc  <= acc ^ rx_data_i;
            word <= word_nxt;
            if (bcnt == BC_W'(BPW - 1)) begin
              bcnt        <= '0;
              state       <= S_WR;
              rx_ready_o  <= 1'b0;
              imem_we_o   <= 1'b1;
              imem_addr_o <= count_o[ADDR_W-1:0];
              imem_data_o <= word_nxt;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        S_WR: begin
          count_o    <= count_inc;
          rx_ready_o <= 1'b1;
          state      <= (count_inc == n_words) ? S_CHK : S_DATA;
        end
        S_CHK: begin
          if (take) begin
            rx_ready_o <= 1'b0;
            if (rx_data_i == acc) begin
              state      <= S_DONE;
              done_o     <= 1'b1;
              cpu_hold_o <= 1'b0;
            end else begin
              // Hold stays asserted so a partial program never runs.
              state <= S_ERR;
              err_o <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
